// File: rtl/leaf_stream_fifo.sv
// leaf_stream_fifo: valid/ready elastic buffer with first-word fall-through
// read side, occupancy output and a saturating count of completed output
// transfers. Full/empty decisions come only from the occupancy register.
module leaf_stream_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNT_W-1:0]           xfer_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

    // Storage is deliberately left out of reset; only pointers/level clear.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

    logic push;
    logic pop;

    // Handshake qualifiers and output view of the head entry
    always_comb begin
        in_ready  = rst_n & (level_q != LEVEL_FULL);
        out_valid = (level_q != '0);
        out_data  = out_valid ? mem[rd_ptr_q] : '0;
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
    end

    // Next-state for pointers, occupancy and the saturating transfer counter
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        xfer_cnt_d = xfer_cnt_q;

        // Pointers are exactly log2(DEPTH) bits, so +1 wraps on its own.
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            if (xfer_cnt_q != '1) begin
                xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
            end
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Control state registers; reset wins over any handshake at the same edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            xfer_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    // Payload write; push already folds in rst_n and the full condition
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

    assign level    = level_q;
    assign xfer_cnt = xfer_cnt_q;

    // Producer must hold a stalled offer (valid and data) until accepted
    a_hold_stalled_offer: assert property (
        @(posedge clk)
        (rst_n && in_valid && !in_ready) |=> (!rst_n || (in_valid && $stable(in_data)))
    );

endmodule
